// File: rtl/uart_pkg.sv
// uart_pkg: shared parity encodings, transmitter state type and accumulator sizing
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD = 1;
  localparam int PAR_EVEN = 2;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} tx_state_t;
  function automatic int accWidth(input longint clkFreq, input longint baud);
    return $clog2(clkFreq + baud);
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: fractional-accumulator bit tick, exact CLK_FREQ/BAUD over the long run
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 25000000,
  parameter int BAUD = 115200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);
  localparam int W = accWidth(CLK_FREQ, BAUD);
  logic [W-1:0] acc, sum;
  assign sum = acc + W'(BAUD);
  assign tick = enable && sum >= W'(CLK_FREQ);
  // held at zero while disabled so the first period after enable is never short
  always_ff @(posedge clk)
    if (!rst_n || !enable) acc <= '0;
    else acc <= tick ? sum - W'(CLK_FREQ) : sum;
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter with configurable data/parity/stop bits,
// sending queued words back-to-back with no idle gap between frames
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 25000000,
  parameter int BAUD = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  output logic                          txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);

  if (CLK_FREQ < 8 * BAUD) begin : gBadRatio
    $error("uart_tx_fifo: CLK_FREQ must be at least 8*BAUD");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : gBadWidth
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : gBadParity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : gBadStop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : gBadDepth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wrPtr, rdPtr;
  logic [DATA_BITS-1:0] head, shift, shiftNext;
  logic [3:0] bitIdx, bitIdxNext;
  logic push, pop, tick, stopCnt, stopCntNext, parBit, parBitNext, txdNext;
  tx_state_t state, stateNext;

  assign fifo_count = wrPtr - rdPtr;
  assign tx_ready = fifo_count != (AW + 1)'(FIFO_DEPTH);
  assign push = tx_valid & tx_ready;
  assign head = mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk)
    if (push) mem[wrPtr[AW-1:0]] <= tx_data;

  always_ff @(posedge clk)
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop) rdPtr <= rdPtr + 1'b1;
    end

  uart_baud_gen #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) baudGen (
    .clk(clk),
    .rst_n(rst_n),
    .enable(state != S_IDLE),
    .tick(tick)
  );

  always_comb begin
    stateNext = state;
    shiftNext = shift;
    bitIdxNext = bitIdx;
    stopCntNext = stopCnt;
    parBitNext = parBit;
    pop = 1'b0;
    case (state)
      S_IDLE: pop = fifo_count != '0;
      S_START: if (tick) begin
        stateNext = S_DATA;
        bitIdxNext = '0;
      end
      S_DATA: if (tick) begin
        shiftNext = shift >> 1;
        bitIdxNext = bitIdx + 1'b1;
        stopCntNext = 1'b0;
        if (bitIdx == 4'(DATA_BITS - 1)) stateNext = PARITY != PAR_NONE ? S_PARITY : S_STOP;
      end
      S_PARITY: if (tick) begin
        stateNext = S_STOP;
        stopCntNext = 1'b0;
      end
      S_STOP: if (tick) begin
        if (stopCnt == 1'(STOP_BITS - 1)) begin
          pop = fifo_count != '0;
          stateNext = S_IDLE;
        end else stopCntNext = 1'b1;
      end
      default: stateNext = S_IDLE;
    endcase
    // a pop always starts a new frame, whether from idle or straight out of the last stop bit
    if (pop) begin
      stateNext = S_START;
      shiftNext = head;
      parBitNext = ^head ^ (PARITY == PAR_ODD);
    end
    txdNext = state == S_START ? 1'b0 : state == S_DATA ? shift[0] : state == S_PARITY ? parBit : 1'b1;
  end

  // txd and tx_busy both lag the state by one clock, keeping them aligned on the pin
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= S_IDLE;
      shift <= '0;
      bitIdx <= '0;
      stopCnt <= 1'b0;
      parBit <= 1'b0;
      txd <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      state <= stateNext;
      shift <= shiftNext;
      bitIdx <= bitIdxNext;
      stopCnt <= stopCntNext;
      parBit <= parBitNext;
      txd <= txdNext;
      tx_busy <= state != S_IDLE || fifo_count != '0;
    end
endmodule
